// File: rtl/ball_hit_resolver.sv
// rtl/ball_hit_resolver.sv - ball vs opponent hitbox resolver: damage, hit-stun, knockback, KO
module ball_hit_resolver #(
  parameter int BALL_W       = 16,
  parameter int BALL_H       = 16,
  parameter int OPP_W        = 40,
  parameter int OPP_H        = 80,
  parameter int DAMAGE       = 10,
  parameter int BLOCK_DAMAGE = 2,
  parameter int STUN_FRAMES  = 12,
  parameter int MAX_HEALTH   = 100
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       summoned_ball,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       ball_face,
  input  logic [9:0] opp_x,
  input  logic [9:0] opp_y,
  input  logic       opp_block,
  output logic       hit_pulse,
  output logic       kill_ball,
  output logic       knock_dir,
  output logic       stun_active,
  output logic [7:0] opp_health,
  output logic       ko
);

  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_STUN  = 2'd1;
  localparam logic [1:0] ST_KO    = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_stun_cnt;
  logic       r_armed;
  logic       r_prev_summoned;

  logic       w_overlap;
  logic       w_rise;
  logic       w_fall;
  logic       w_hit;
  logic [7:0] w_dmg;
  logic [7:0] w_health_after;
  logic [7:0] w_health_next;

  // 11-bit sums so a ball near the right/bottom edge cannot wrap into a false overlap
  always_comb begin
    w_overlap = (({1'b0, ball_x} + 11'(BALL_W)) > {1'b0, opp_x}) &&
                ({1'b0, ball_x} < ({1'b0, opp_x} + 11'(OPP_W))) &&
                (({1'b0, ball_y} + 11'(BALL_H)) > {1'b0, opp_y}) &&
                ({1'b0, ball_y} < ({1'b0, opp_y} + 11'(OPP_H)));
    w_rise         = summoned_ball & ~r_prev_summoned;
    w_fall         = ~summoned_ball & r_prev_summoned;
    w_hit          = summoned_ball & r_armed & w_overlap & (r_state != ST_KO);
    w_dmg          = opp_block ? 8'(BLOCK_DAMAGE) : 8'(DAMAGE);
    w_health_after = (opp_health > w_dmg) ? (opp_health - w_dmg) : 8'd0;
    w_health_next  = w_hit ? w_health_after : opp_health;
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      hit_pulse       <= 1'b0;
      kill_ball       <= 1'b0;
      knock_dir       <= 1'b0;
      stun_active     <= 1'b0;
      ko              <= 1'b0;
      opp_health      <= 8'(MAX_HEALTH);
      r_stun_cnt      <= 8'd0;
      r_armed         <= 1'b0;
      r_prev_summoned <= 1'b0;
      r_state         <= ST_ALIVE;
    end else begin
      r_prev_summoned <= summoned_ball;
      hit_pulse       <= w_hit;
      kill_ball       <= w_hit;
      if (w_hit) begin
        knock_dir  <= ball_face;
        opp_health <= w_health_after;
      end

      if (w_hit)       r_armed <= 1'b0;
      else if (w_rise) r_armed <= 1'b1;
      else if (w_fall) r_armed <= 1'b0;

      // Reaching zero health overrides any stun bookkeeping on the same edge
      if (r_state != ST_KO && w_health_next == 8'd0) begin
        r_state     <= ST_KO;
        ko          <= 1'b1;
        stun_active <= 1'b0;
        r_stun_cnt  <= 8'd0;
      end else begin
        case (r_state)
          ST_ALIVE: begin
            if (w_hit && !opp_block) begin
              r_stun_cnt  <= 8'(STUN_FRAMES - 1);
              stun_active <= 1'b1;
              r_state     <= ST_STUN;
            end
          end
          ST_STUN: begin
            if (r_stun_cnt == 8'd0) begin
              stun_active <= 1'b0;
              r_state     <= ST_ALIVE;
            end else begin
              r_stun_cnt <= r_stun_cnt - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ball_hit_resolver.md
Name: ball_hit_resolver

Overview:
- Downstream consumer of the projectile ball stage. Each frame it takes the ball position, the ball-active flag and the ball facing, and tests them against the opponent hitbox.
- On a hit it applies damage to the opponent health, runs a hit-stun timer, latches the knockback direction, and asks the ball stage to despawn.
- Feeds the health bar renderer and the opponent movement FSM.

Parameters:
- BALL_W, 16, ball sprite width in pixels
- BALL_H, 16, ball sprite height in pixels
- OPP_W, 40, opponent hitbox width in pixels
- OPP_H, 80, opponent hitbox height in pixels
- DAMAGE, 10, health removed by an unblocked hit
- BLOCK_DAMAGE, 2, health removed by a blocked hit
- STUN_FRAMES, 12, frames spent in hit-stun after an unblocked hit
- MAX_HEALTH, 100, health value after reset (must be 255 or less)

Ports:
- frame_clk  in  1  frame clock; the only clock
- Reset_n  in  1  synchronous active-low reset
- summoned_ball  in  1  ball is in flight
- ball_x  in  10  ball top-left x
- ball_y  in  10  ball top-left y
- ball_face  in  1  ball direction (0 = moving right, 1 = moving left)
- opp_x  in  10  opponent hitbox top-left x
- opp_y  in  10  opponent hitbox top-left y
- opp_block  in  1  opponent is holding block
- hit_pulse  out  1  one-frame strobe for each registered hit
- kill_ball  out  1  one-frame strobe asking the ball stage to despawn
- knock_dir  out  1  latched ball_face of the last hit
- stun_active  out  1  opponent is in hit-stun
- opp_health  out  8  remaining opponent health
- ko  out  1  health has reached 0; latched

Behaviour:
- Reset: when Reset_n = 0 at a frame_clk edge, all outputs take these values on that edge:
  - hit_pulse = 0, kill_ball = 0, knock_dir = 0, stun_active = 0, ko = 0
  - opp_health = MAX_HEALTH
  - stun counter = 0, armed = 0, previous summoned_ball = 0, state = ALIVE
- Reset mid-stun or mid-KO returns to ALIVE with full health.
- Overlap test (combinational, widened to 11 bits so sums cannot wrap). overlap = 1 when all four hold:
  - ball_x + BALL_W > opp_x
  - ball_x < opp_x + OPP_W
  - ball_y + BALL_H > opp_y
  - ball_y < opp_y + OPP_H
  - Edges that only touch do not count as overlap.
- Arming:
  - A rising summoned_ball (registered previous value 0, current value 1) sets armed.
  - A falling summoned_ball clears armed.
  - Each flight can therefore hit at most once.
- Hit condition: hit = summoned_ball & armed & overlap & (state != KO).
  - Evaluated on the inputs sampled at edge N.
  - All effects are visible after edge N, i.e. during frame N+1.
- On hit:
  - hit_pulse = 1 and kill_ball = 1 for exactly one frame.
  - armed cleared; knock_dir = ball_face.
  - damage d = BLOCK_DAMAGE if opp_block = 1, else DAMAGE.
- State ALIVE:
  - Unblocked hit: opp_health reduced by d, saturating at 0. Stun counter loaded with STUN_FRAMES - 1; stun_active = 1; go to STUN.
  - Blocked hit: opp_health reduced by d, saturating at 0; stay in ALIVE; no stun.
- State STUN:
  - The counter decrements every frame. When it is 0 at an edge, stun_active = 0 and the state returns to ALIVE.
  - stun_active is therefore high for exactly STUN_FRAMES frames.
  - A hit during STUN still strobes hit_pulse and kill_ball and still applies d, but does not reload the counter.
- KO:
  - If the health after subtraction is 0, then on that same edge ko = 1, stun_active = 0 and state = KO, overriding STUN.
  - KO is absorbing until reset. In KO, hit is suppressed: no pulses, armed is ignored, health is frozen at 0.
- Simultaneous events:
  - A summoned_ball rise and an overlap in the same frame give no hit; armed takes effect from the next frame.
  - A summoned_ball fall and an overlap in the same frame give no hit, because the hit condition requires summoned_ball = 1.
- Invalid parameters: if MAX_HEALTH is 0, ko is set on the first edge after reset is released.

Test Plan:
- Reset then idle: Reset_n low for 2 frames, then summoned_ball = 0 for 5 frames -> opp_health = 100, ko = 0, stun_active = 0, no pulses.
- Single unblocked hit:
  - Stimulus: summoned_ball rises at frame 0. At frame 3, ball_x = 205, ball_y = 140, opp = (200,100), opp_block = 0.
  - Required: hit_pulse and kill_ball high only in frame 4; opp_health = 90; stun_active high for exactly 12 frames; knock_dir = ball_face.
- Blocked hit plus one-hit-per-flight:
  - Stimulus: same geometry with opp_block = 1; overlap held for 6 frames.
  - Required: exactly one hit_pulse; opp_health = 98; stun_active stays 0.
- Edge touching: ball_x = 184 (ball_x + 16 = opp_x = 200) -> no hit. ball_x = 185 -> hit.
- Hit during stun: second flight hits 5 frames into the stun -> pulse fires, health 90 -> 80, stun ends 12 frames after the first hit.
- KO and reset:
  - Stimulus: 10 unblocked flights.
  - Required: opp_health = 0; ko = 1 on the tenth hit's edge; stun_active = 0.
  - An eleventh overlapping flight gives no pulse.
  - Reset_n low for 1 frame -> opp_health = 100, ko = 0.
